// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner: debug reader for the processor's register-snoop port.
// A start pulse emits the PC as the first frame, then walks syn_reg_dst over
// every register and emits each sampled value as a tagged 32-bit frame on a
// valid/ready stream. The core keeps running, so a dump is not atomic.
// Optional build macro REG_DUMP_SKIP_ZERO_EN: registers that read as zero
// produce no frame. The PC frame is always sent.
module reg_dump_scanner #(
   parameter int NUM_REGS      = 32,
   parameter int SETTLE_CYCLES = 1,
   parameter int PC_TAG        = 63
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] syn_pc,
   input  logic [31:0] syn_reg_out,
   output logic [4:0]  syn_reg_dst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [5:0]  out_tag,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SEND, SETTLE} state_t;

   localparam int              CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [5:0]      LAST_IDX = 6'(NUM_REGS - 1);
   localparam logic [5:0]      PC_TAG_V = 6'(PC_TAG);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);

   state_t            state, state_next;
   logic [5:0]        idx, idx_next, idx_inc;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [4:0]        dst_next;
   logic              valid_next, busy_next, done_next, skip_zero;
   logic [31:0]       data_next;
   logic [5:0]        tag_next;

   assign idx_inc = idx + 6'd1;

   // Zero-valued registers are only dropped when the skip feature is built in.
`ifdef REG_DUMP_SKIP_ZERO_EN
   assign skip_zero = (syn_reg_out == 32'd0);
`else
   assign skip_zero = 1'b0;
`endif

   // Register the FSM state together with every output and scan counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= 6'd0;
         cnt         <= '0;
         syn_reg_dst <= 5'd0;
         out_valid   <= 1'b0;
         out_data    <= 32'd0;
         out_tag     <= 6'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         cnt         <= cnt_next;
         syn_reg_dst <= dst_next;
         out_valid   <= valid_next;
         out_data    <= data_next;
         out_tag     <= tag_next;
         busy        <= busy_next;
         done        <= done_next;
      end
   end

   // Next-state and next-output logic; everything holds unless a step changes it.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      cnt_next   = cnt;
      dst_next   = syn_reg_dst;
      valid_next = out_valid;
      data_next  = out_data;
      tag_next   = out_tag;
      busy_next  = busy;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               data_next  = syn_pc;
               tag_next   = PC_TAG_V;
               valid_next = 1'b1;
               busy_next  = 1'b1;
               idx_next   = 6'd0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               valid_next = 1'b0;
               if (out_tag == PC_TAG_V) begin
                  idx_next   = 6'd0;
                  dst_next   = 5'd0;
                  cnt_next   = CNT_INIT;
                  state_next = SETTLE;
               end else if (idx == LAST_IDX) begin
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  idx_next   = idx_inc;
                  dst_next   = idx_inc[4:0];
                  cnt_next   = CNT_INIT;
                  state_next = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (cnt != '0) begin
               cnt_next = cnt - CNT_W'(1);
            end else if (skip_zero) begin
               if (idx == LAST_IDX) begin
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  idx_next = idx_inc;
                  dst_next = idx_inc[4:0];
                  cnt_next = CNT_INIT;
               end
            end else begin
               data_next  = syn_reg_out;
               tag_next   = {1'b0, syn_reg_dst};
               valid_next = 1'b1;
               state_next = SEND;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed bench for reg_dump_scanner: reset, full dumps, backpressure,
// mid-dump start/reset, a single-register zero-settle instance, and the
// zero-skip option when REG_DUMP_SKIP_ZERO_EN is defined.
module tb_reg_dump_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] syn_pc = 32'd0;
   logic [31:0] syn_reg_out;
   logic [4:0]  syn_reg_dst;
   logic        out_valid;
   logic [31:0] out_data;
   logic [5:0]  out_tag;
   logic        busy;
   logic        done;

   logic        start2 = 1'b0;
   logic        out_ready2 = 1'b1;
   logic [31:0] reg0_2 = 32'hCAFE_0001;
   logic [4:0]  syn_reg_dst2;
   logic        out_valid2;
   logic [31:0] out_data2;
   logic [5:0]  out_tag2;
   logic        busy2;
   logic        done2;

   logic [31:0] core_regs [0:31];
   logic [31:0] pc_exp;
   int          n_assert = 0;
   int          n_fail = 0;

   assign syn_reg_out = core_regs[syn_reg_dst];

   always #5 clk = ~clk;

   reg_dump_scanner dut (
      .clk(clk), .rst_n(rst_n), .start(start), .syn_pc(syn_pc),
      .syn_reg_out(syn_reg_out), .syn_reg_dst(syn_reg_dst),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .busy(busy), .done(done)
   );

   reg_dump_scanner #(.NUM_REGS(1), .SETTLE_CYCLES(0), .PC_TAG(63)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .syn_pc(syn_pc),
      .syn_reg_out(reg0_2), .syn_reg_dst(syn_reg_dst2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .out_tag(out_tag2), .busy(busy2), .done(done2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Tick until a frame is valid, bounded by limit cycles.
   task automatic next_frame(input int limit, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!out_valid && cyc < limit);
      check("frame_valid", 32'(out_valid), 32'd1);
   endtask

   // Frame 0 is the PC frame, frame f>0 carries register f-1 = (f-1)*4+1.
   task automatic check_frame(input int f);
      if (f == 0) begin
         check("pc_tag", 32'(out_tag), 32'd63);
         check("pc_data", out_data, pc_exp);
      end else begin
         check($sformatf("tag_f%0d", f), 32'(out_tag), 32'(f - 1));
         check($sformatf("data_f%0d", f), out_data, 32'((f - 1) * 4 + 1));
      end
   endtask

   task automatic check_done_seq();
      tick();
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_valid", 32'(out_valid), 32'd0);
      tick();
      check("done_clear", 32'(done), 32'd0);
   endtask

   task automatic start_dump(input logic [31:0] pc);
      syn_pc = pc;
      pc_exp = pc;
      start = 1'b1;
      tick();
      start = 1'b0;
      syn_pc = ~pc;
      check("pc_valid", 32'(out_valid), 32'd1);
      check("pc_busy", 32'(busy), 32'd1);
      check_frame(0);
   endtask

   task automatic full_dump(input logic [31:0] pc, input bit bp, input bit cadence);
      int  cyc;
      bit  stable;
      start_dump(pc);
      for (int f = 1; f <= 32; f++) begin
         next_frame(20, cyc);
         check_frame(f);
         if (cadence) check($sformatf("cadence_f%0d", f), 32'(cyc), 32'd3);
         if (bp && f == 6) begin
            out_ready = 1'b0;
            stable = 1'b1;
            repeat (10) begin
               tick();
               if (!(out_valid && out_data == 32'd21 && out_tag == 6'd5)) stable = 1'b0;
            end
            check("bp_stable", 32'(stable), 32'd1);
            out_ready = 1'b1;
         end
      end
      check_done_seq();
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_dst"}, 32'(syn_reg_dst), 32'd0);
      check({pfx, "_valid"}, 32'(out_valid), 32'd0);
      check({pfx, "_data"}, out_data, 32'd0);
      check({pfx, "_tag"}, 32'(out_tag), 32'd0);
      check({pfx, "_busy"}, 32'(busy), 32'd0);
      check({pfx, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 32; i++) core_regs[i] = 32'(i * 4 + 1);

      // Reset held with start asserted
      rst_n = 1'b0;
      start = 1'b1;
      repeat (3) tick();
      check_reset_outputs("rst");
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) tick();
      check("idle_busy", 32'(busy), 32'd0);

      // Full dump with cadence
      full_dump(32'h0040_1A2C, 1'b0, 1'b1);

      // Backpressure on register 5
      full_dump(32'h0000_8000, 1'b1, 1'b0);

      // Start while busy is ignored, then reset at frame 12
      start_dump(32'h1234_5678);
      for (int f = 1; f <= 12; f++) begin
         next_frame(20, cyc);
         check_frame(f);
         if (f == 3) begin
            start = 1'b1;
            tick();
            start = 1'b0;
         end
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      full_dump(32'h0BAD_F00D, 1'b0, 1'b1);

      // Single register, zero settle cycles
      syn_pc = 32'h0000_0444;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("s_pc_valid", 32'(out_valid2), 32'd1);
      check("s_pc_tag", 32'(out_tag2), 32'd63);
      check("s_pc_data", out_data2, 32'h0000_0444);
      tick();
      check("s_gap_valid", 32'(out_valid2), 32'd0);
      tick();
      check("s_r0_valid", 32'(out_valid2), 32'd1);
      check("s_r0_tag", 32'(out_tag2), 32'd0);
      check("s_r0_data", out_data2, 32'hCAFE_0001);
      tick();
      check("s_done", 32'(done2), 32'd1);
      check("s_done_valid", 32'(out_valid2), 32'd0);
      tick();
      check("s_done_clear", 32'(done2), 32'd0);

`ifdef REG_DUMP_SKIP_ZERO_EN
      // Only registers 3 and 31 nonzero
      for (int i = 0; i < 32; i++) core_regs[i] = 32'd0;
      core_regs[3]  = 32'h0000_0033;
      core_regs[31] = 32'h0000_0077;
      start_dump(32'h0000_5000);
      next_frame(100, cyc);
      check("sk_tag3", 32'(out_tag), 32'd3);
      check("sk_data3", out_data, 32'h0000_0033);
      next_frame(100, cyc);
      check("sk_tag31", 32'(out_tag), 32'd31);
      check("sk_data31", out_data, 32'h0000_0077);
      check_done_seq();

      // All registers zero
      core_regs[3]  = 32'd0;
      core_regs[31] = 32'd0;
      start_dump(32'h0000_6000);
      begin
         bit saw_valid;
         bit saw_done;
         saw_valid = 1'b0;
         saw_done  = 1'b0;
         tick();
         for (int c = 0; c < 200 && !saw_done; c++) begin
            if (out_valid) saw_valid = 1'b1;
            if (done) saw_done = 1'b1;
            else tick();
         end
         check("sk_zero_done", 32'(saw_done), 32'd1);
         check("sk_zero_noframe", 32'(saw_valid), 32'd0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
